// File: rtl/hazard_unit.sv
// Decode-stage hazard/forwarding controller: 3-entry in-flight scoreboard (EX/MEM/WB),
// load-use stall, branch flush, operand forward selects. Optional HAZ_STATS_EN adds stall_cnt.
module hazard_unit #(
    parameter logic [1:0] ZERO_FWD = 2'b00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] id_rn,
    input  logic [3:0] id_rm,
    input  logic [3:0] id_rs,
    input  logic       id_use_rn,
    input  logic       id_use_rm,
    input  logic       id_use_rs,
    input  logic [3:0] id_rd,
    input  logic       id_rf_e,
    input  logic       id_load,
    input  logic       ex_branch_taken,
    output logic       nop_s,
    output logic       pc_le,
    output logic       ifid_le,
    output logic       ifid_flush,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic [1:0] fwd_c
`ifdef HAZ_STATS_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    typedef struct packed {
        logic       v;
        logic [3:0] rd;
        logic       ld;
    } sb_entry_t;

    sb_entry_t ex_q, mem_q, wb_q, ex_d;

    logic [2:0][3:0] src_reg;
    logic [2:0]      src_use;
    logic [2:0][1:0] fwd_sel;
    logic [2:0]      src_ex_ld;
    logic            load_use;
    logic            stall;
    logic            branch_kill;

    assign src_reg = {id_rs, id_rm, id_rn};
    assign src_use = {id_use_rs, id_use_rm, id_use_rn};

    function automatic logic hit(input sb_entry_t e, input logic use_src, input logic [3:0] r);
        // R15 reads the PC path, so it is never treated as a register dependency
        return use_src && (r != 4'd15) && e.v && (e.rd == r);
    endfunction

    function automatic logic [1:0] fwd_code(input sb_entry_t ex_e, input sb_entry_t mem_e,
                                            input sb_entry_t wb_e, input logic use_src,
                                            input logic [3:0] r);
        if (hit(ex_e, use_src, r))       return 2'b01;
        else if (hit(mem_e, use_src, r)) return 2'b10;
        else if (hit(wb_e, use_src, r))  return 2'b11;
        else                             return ZERO_FWD;
    endfunction

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_src
            assign fwd_sel[gi]   = fwd_code(ex_q, mem_q, wb_q, src_use[gi], src_reg[gi]);
            assign src_ex_ld[gi] = hit(ex_q, src_use[gi], src_reg[gi]) && ex_q.ld;
        end
    endgenerate

    assign load_use    = |src_ex_ld;
    // A taken branch makes the ID instruction wrong-path, so its stall is dropped
    assign branch_kill = rst_n && ex_branch_taken;
    assign stall       = rst_n && load_use && !ex_branch_taken;

    assign nop_s      = !rst_n || ex_branch_taken || load_use;
    assign pc_le      = rst_n && !stall;
    assign ifid_le    = rst_n && !stall;
    assign ifid_flush = branch_kill;
    assign fwd_a      = rst_n ? fwd_sel[0] : ZERO_FWD;
    assign fwd_b      = rst_n ? fwd_sel[1] : ZERO_FWD;
    assign fwd_c      = rst_n ? fwd_sel[2] : ZERO_FWD;

    always_comb begin
        ex_d    = '0;
        ex_d.v  = id_rf_e && !nop_s;
        ex_d.rd = id_rd;
        ex_d.ld = id_load && !nop_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

`ifdef HAZ_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: age-indexed issue history model checked every cycle,
// plus directed literal checks. Checks stall_cnt when HAZ_STATS_EN is defined.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] id_rn = '0, id_rm = '0, id_rs = '0, id_rd = '0;
    logic       id_use_rn = 0, id_use_rm = 0, id_use_rs = 0;
    logic       id_rf_e = 0, id_load = 0, ex_branch_taken = 0;
    logic       nop_s, pc_le, ifid_le, ifid_flush;
    logic [1:0] fwd_a, fwd_b, fwd_c;
`ifdef HAZ_STATS_EN
    logic [15:0] stall_cnt;
`endif

    int total = 0;
    int bad = 0;

    hazard_unit dut (
        .clk(clk), .rst_n(rst_n),
        .id_rn(id_rn), .id_rm(id_rm), .id_rs(id_rs),
        .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rs(id_use_rs),
        .id_rd(id_rd), .id_rf_e(id_rf_e), .id_load(id_load),
        .ex_branch_taken(ex_branch_taken),
        .nop_s(nop_s), .pc_le(pc_le), .ifid_le(ifid_le), .ifid_flush(ifid_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_c(fwd_c)
`ifdef HAZ_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // hist_*[k] describes the instruction issued k edges ago (1 = now in EX).
    logic       hist_w  [1:3];
    logic [3:0] hist_rd [1:3];
    logic       hist_ld [1:3];
    int         m_cnt;

    function automatic int age_of(input logic u, input logic [3:0] r);
        if (!u || r == 4'd15) return 0;
        for (int k = 1; k <= 3; k++)
            if (hist_w[k] && hist_rd[k] == r) return k;
        return 0;
    endfunction

    function automatic logic m_loaduse();
        logic lu = 0;
        if (age_of(id_use_rn, id_rn) == 1 && hist_ld[1]) lu = 1;
        if (age_of(id_use_rm, id_rm) == 1 && hist_ld[1]) lu = 1;
        if (age_of(id_use_rs, id_rs) == 1 && hist_ld[1]) lu = 1;
        return lu;
    endfunction

    function automatic logic m_nop();
        return !rst_n || ex_branch_taken || m_loaduse();
    endfunction

    function automatic logic m_stall();
        return rst_n && !ex_branch_taken && m_loaduse();
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= 3; k++) begin
                hist_w[k]  <= 0;
                hist_rd[k] <= 0;
                hist_ld[k] <= 0;
            end
            m_cnt <= 0;
        end else begin
            hist_w[1]  <= id_rf_e && !m_nop();
            hist_rd[1] <= id_rd;
            hist_ld[1] <= id_load && !m_nop();
            for (int k = 2; k <= 3; k++) begin
                hist_w[k]  <= hist_w[k-1];
                hist_rd[k] <= hist_rd[k-1];
                hist_ld[k] <= hist_ld[k-1];
            end
            if (m_stall() && m_cnt < 65535) m_cnt <= m_cnt + 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, on the falling edge
    always @(negedge clk) begin
        chk("nop_s", int'(nop_s), int'(m_nop()));
        chk("pc_le", int'(pc_le), int'(rst_n && !m_stall()));
        chk("ifid_le", int'(ifid_le), int'(rst_n && !m_stall()));
        chk("ifid_flush", int'(ifid_flush), int'(rst_n && ex_branch_taken));
        chk("fwd_a", int'(fwd_a), rst_n ? age_of(id_use_rn, id_rn) : 0);
        chk("fwd_b", int'(fwd_b), rst_n ? age_of(id_use_rm, id_rm) : 0);
        chk("fwd_c", int'(fwd_c), rst_n ? age_of(id_use_rs, id_rs) : 0);
`ifdef HAZ_STATS_EN
        chk("stall_cnt", int'(stall_cnt), m_cnt);
`endif
        $display("cyc t=%0t rst_n=%0b nop_s=%0b pc_le=%0b ifid_le=%0b flush=%0b fwd=%0d/%0d/%0d",
                 $time, rst_n, nop_s, pc_le, ifid_le, ifid_flush, fwd_a, fwd_b, fwd_c);
    end

    // Advance one cycle and present a new ID instruction.
    task automatic cyc(input logic [3:0] rn, input logic urn, input logic [3:0] rm, input logic urm,
                       input logic [3:0] rs, input logic urs, input logic [3:0] rd,
                       input logic rfe, input logic ld, input logic br);
        @(posedge clk);
        #1;
        id_rn = rn; id_use_rn = urn; id_rm = rm; id_use_rm = urm;
        id_rs = rs; id_use_rs = urs; id_rd = rd; id_rf_e = rfe; id_load = ld;
        ex_branch_taken = br;
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic ctl(input string tag, input logic en, input logic ep, input logic ei,
                       input logic ef);
        chk({tag, ".nop_s"}, int'(nop_s), int'(en));
        chk({tag, ".pc_le"}, int'(pc_le), int'(ep));
        chk({tag, ".ifid_le"}, int'(ifid_le), int'(ei));
        chk({tag, ".ifid_flush"}, int'(ifid_flush), int'(ef));
    endtask

    initial begin
        // Reset held for 3 cycles
        repeat (3) @(posedge clk);
        #2;
        ctl("reset", 1, 0, 0, 0);
        chk("reset.fwd", int'({fwd_a, fwd_b, fwd_c}), 0);
        #1 rst_n = 1'b1;
        #1;
        ctl("release", 0, 1, 1, 0);
        chk("release.fwd", int'({fwd_a, fwd_b, fwd_c}), 0);

        // EX -> MEM -> WB forwarding of R5
        cyc(0, 0, 0, 0, 0, 0, 5, 1, 0, 0);
        cyc(5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("fwd_ex", int'(fwd_a), 1);
        cyc(5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("fwd_mem", int'(fwd_a), 2);
        cyc(5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("fwd_wb", int'(fwd_a), 3);
        cyc(5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("fwd_none", int'(fwd_a), 0);

        // Priority: R3 in MEM and EX
        cyc(0, 0, 0, 0, 0, 0, 3, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 3, 1, 0, 0);
        cyc(0, 0, 3, 1, 0, 0, 0, 0, 0, 0);
        chk("prio_ex", int'(fwd_b), 1);

        // R15 loaded then read: no forward, no stall
        cyc(0, 0, 0, 0, 0, 0, 15, 1, 1, 0);
        cyc(15, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("r15_fwd", int'(fwd_a), 0);
        ctl("r15", 0, 1, 1, 0);

        // Independent per-source selects
        cyc(0, 0, 0, 0, 0, 0, 7, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 8, 1, 0, 0);
        cyc(8, 1, 7, 1, 8, 0, 0, 0, 0, 0);
        chk("multi_a", int'(fwd_a), 1);
        chk("multi_b", int'(fwd_b), 2);
        chk("multi_c_unused", int'(fwd_c), 0);

        // Load-use on R2
        cyc(0, 0, 0, 0, 0, 0, 2, 1, 1, 0);
        cyc(2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        ctl("loaduse", 1, 0, 0, 0);
        cyc(2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        ctl("after_stall", 0, 1, 1, 0);
        chk("after_stall.fwd_a", int'(fwd_a), 2);
`ifdef HAZ_STATS_EN
        chk("stall_cnt_1", int'(stall_cnt), 1);
`endif

        // Branch coincides with load-use
        cyc(0, 0, 0, 0, 0, 0, 2, 1, 1, 0);
        cyc(2, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        ctl("br_vs_lu", 1, 1, 1, 1);
        idle();
        ctl("post_branch", 0, 1, 1, 0);
`ifdef HAZ_STATS_EN
        chk("stall_cnt_br", int'(stall_cnt), 1);
`endif

        // Reset during a load-use stall
        cyc(0, 0, 0, 0, 0, 0, 2, 1, 1, 0);
        cyc(2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        ctl("pre_rst_stall", 1, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        ctl("mid_rst", 1, 0, 0, 0);
        chk("mid_rst.fwd_a", int'(fwd_a), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        ctl("rst_release", 0, 1, 1, 0);
        chk("rst_release.fwd", int'({fwd_a, fwd_b, fwd_c}), 0);
`ifdef HAZ_STATS_EN
        chk("stall_cnt_rst", int'(stall_cnt), 0);
`endif

        // Mixed traffic on a small register window, checked by the model
        for (int i = 0; i < 40; i++) begin
            cyc(4'($urandom_range(0, 3)), 1'($urandom), 4'($urandom_range(0, 3)), 1'($urandom),
                4'($urandom_range(0, 3)), 1'($urandom), 4'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom), 1'($urandom_range(0, 5) == 0));
        end
        idle();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard and forwarding controller for the ARM decode stage. It drives the NOP-select `S` input of the decode-stage control multiplexer, and the load enables of the PC and the IF/ID register. It keeps its own 3-entry scoreboard of in-flight destination registers (EX, MEM, WB) so that it can detect load-use hazards and produce operand forwarding selects. It also turns a branch resolved in EX into a fetch/decode flush.

## Interface
- `ZERO_FWD`, default 0, forwarding code meaning "use register file".
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_rn`, `id_rm`, `id_rs` in 4 each: source register numbers of the instruction in ID.
- `id_use_rn`, `id_use_rm`, `id_use_rs` in 1 each: corresponding source is actually read.
- `id_rd` in 4: destination register of the instruction in ID.
- `id_rf_e` in 1: instruction in ID writes the register file (RF_E from the control unit).
- `id_load` in 1: instruction in ID is a load (ID_LOAD from the control unit).
- `ex_branch_taken` in 1: branch/BL in EX resolved taken this cycle.
- `nop_s` out 1: S to the control multiplexer; 1 inserts a NOP (all control signals 0).
- `pc_le` out 1: PC load enable.
- `ifid_le` out 1: IF/ID register load enable.
- `ifid_flush` out 1: clear IF/ID to a NOP on the next edge.
- `fwd_a`, `fwd_b`, `fwd_c` out 2 each: forward select for Rn, Rm, Rs.
  - 00 = register file, 01 = EX result, 10 = MEM result, 11 = WB result.

## Operation
- Scoreboard entries EX, MEM, WB each hold {v, rd[3:0], ld}.
- On every rising edge:
  - WB ← MEM, MEM ← EX.
  - EX ← {id_rf_e & ~nop_s, id_rd, id_load & ~nop_s}.
  - The scoreboard always advances; a stall only injects a bubble into EX.
- Match rule for a source X: `id_use_X`, entry v = 1, entry rd == X, and X != 15. A read of R15 never forwards and never stalls.
- Forwarding priority (per source, independent): EX (01) > MEM (10) > WB (11) > none (00).
- Load-use: if any used source matches EX with ld = 1, then `nop_s` = 1, `pc_le` = 0, `ifid_le` = 0.
- Branch: if `ex_branch_taken` = 1, then `nop_s` = 1, `ifid_flush` = 1, `pc_le` = 1, `ifid_le` = 1.
- Simultaneous branch and load-use: branch wins. The stall is suppressed because the ID instruction is wrong-path.
- Otherwise: `nop_s` = 0, `pc_le` = 1, `ifid_le` = 1, `ifid_flush` = 0.
- Forward selects are computed even while stalling. Consumers ignore them when `nop_s` = 1.

## Timing
- All outputs are combinational from the scoreboard and the ID/EX inputs, valid in the same cycle.
- The scoreboard updates on the rising edge.
- A load-use stall lasts exactly 1 cycle. In the next cycle the load sits in MEM and the dependent source gets `fwd` = 10.
- A flush lasts 1 cycle per `ex_branch_taken` pulse. Zero-cycle penalty beyond the killed ID and IF slots.
- While `rst_n` = 0:
  - All scoreboard entries are cleared to v = 0, ld = 0, rd = 0.
  - `nop_s` = 1, `pc_le` = 0, `ifid_le` = 0, `ifid_flush` = 0, all fwd = 00.
- First cycle after `rst_n` rises: `nop_s` = 0, `pc_le` = 1, `ifid_le` = 1, fwd = 00.
- Reset asserted mid-stall clears the scoreboard immediately. No stall persists after release.

## Configuration
- `HAZ_STATS_EN` defined:
  - Adds output `stall_cnt` [15:0], which increments on each edge where the load-use stall is active.
  - Saturates at 16'hFFFF and resets to 0 on `rst_n`.
  - Flush cycles are not counted.
- `HAZ_STATS_EN` undefined: the port and the counter are absent; all other behaviour is identical.

## Test plan
- Reset: hold `rst_n` = 0 for 3 cycles -> `nop_s` = 1, `pc_le` = 0, `ifid_le` = 0, fwd = 00. After release with no hazards -> `nop_s` = 0, `pc_le` = 1, `ifid_le` = 1.
- EX forwarding: ADD R5 (`id_rf_e` = 1, `id_rd` = 5), then next cycle an instruction with `id_rn` = 5, `id_use_rn` = 1 -> `fwd_a` = 01. One cycle later the same read gives `fwd_a` = 10, and two cycles later `fwd_a` = 11.
- Priority: R3 written by consecutive instructions in MEM and EX, then ID reads `id_rm` = 3 -> `fwd_b` = 01. A read of `id_rn` = 15 matching an entry with rd = 15 -> `fwd_a` = 00 and no stall.
- Load-use: LDRB R2 (`id_load` = 1, `id_rd` = 2), then ID reads `id_rn` = 2 -> one cycle with `nop_s` = 1, `pc_le` = 0, `ifid_le` = 0. Next cycle `nop_s` = 0 and `fwd_a` = 10. With `HAZ_STATS_EN`, `stall_cnt` goes 0 -> 1.
- Branch vs load-use: the load-use condition above plus `ex_branch_taken` = 1 in the same cycle -> `nop_s` = 1, `ifid_flush` = 1, `pc_le` = 1, `ifid_le` = 1, and `stall_cnt` is unchanged.
- Reset mid-stall: assert `rst_n` = 0 during a load-use cycle, then release -> `nop_s` = 0 with all fwd = 00 on the first cycle even though ID still reads R2.
